// File: rtl/sopc_video_cpu_dct_drain_ctrl_pkg.sv
// rtl/sopc_video_cpu_dct_drain_ctrl_pkg.sv - shared constants and state encoding for the trace drain controller
package sopc_video_cpu_dct_pkg;

  localparam int ATOM_W = 2;
  localparam int DEPTH  = 15;
  localparam int BUF_W  = 30;
  localparam int CNT4_W = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } dct_state_e;

endpackage

// File: rtl/sopc_video_cpu_dct_drain_ctrl_if.sv
// rtl/sopc_video_cpu_dct_drain_ctrl_if.sv - atom intake, frame drain and status signals of the drain controller
interface sopc_video_cpu_dct_drain_ctrl_if
  import sopc_video_cpu_dct_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic              atom_valid;
  logic [ATOM_W-1:0] atom;
  logic              atom_ready;
  logic              test_ending;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT4_W-1:0] dct_count;
  logic              frame_valid;
  logic [BUF_W-1:0]  frame_data;
  logic [CNT4_W-1:0] frame_count;
  logic              frame_ready;
  logic              test_has_ended;
  logic [CNT_W-1:0]  frames_sent;

  modport master (
    input  atom_valid, atom, test_ending, frame_ready,
    output atom_ready, dct_buffer, dct_count, frame_valid, frame_data,
           frame_count, test_has_ended, frames_sent
  );

  modport slave (
    output atom_valid, atom, test_ending, frame_ready,
    input  atom_ready, dct_buffer, dct_count, frame_valid, frame_data,
           frame_count, test_has_ended, frames_sent
  );

endinterface

// File: rtl/sopc_video_cpu_dct_frame_reg.sv
// rtl/sopc_video_cpu_dct_frame_reg.sv - single-entry valid/ready holding register for a trace frame
module sopc_video_cpu_dct_frame_reg #(
  parameter int DATA_W  = 30,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DATA_W-1:0]  load_data,
  input  logic [COUNT_W-1:0] load_count,
  input  logic               ready,
  output logic               valid,
  output logic [DATA_W-1:0]  data,
  output logic [COUNT_W-1:0] count
);

  // A load on the same edge as a retire wins, giving back-to-back frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      count <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      count <= load_count;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sopc_video_cpu_dct_drain_ctrl.sv
// rtl/sopc_video_cpu_dct_drain_ctrl.sv - packs trace atoms into frames and sequences the end-of-test flush
module sopc_video_cpu_dct_drain_ctrl
  import sopc_video_cpu_dct_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  sopc_video_cpu_dct_drain_ctrl_if.master bus
);

  dct_state_e        state;
  logic [BUF_W-1:0]  buf_q;
  logic [CNT4_W-1:0] cnt_q;
  logic              ended_q;
  logic [CNT_W-1:0]  sent_q;

  logic              frame_valid;
  logic [BUF_W-1:0]  frame_data;
  logic [CNT4_W-1:0] frame_count;

  logic slot_free;
  logic push;
  logic xfer;
  logic take;

  assign slot_free      = !frame_valid || bus.frame_ready;
  assign bus.atom_ready = (state == RUN) && ((cnt_q < CNT4_W'(DEPTH)) || slot_free);
  assign push           = bus.atom_valid && bus.atom_ready;
  assign take           = frame_valid && bus.frame_ready;
  assign xfer           = slot_free &&
                          (((state == RUN) && (cnt_q == CNT4_W'(DEPTH))) ||
                           ((state == FLUSH) && (cnt_q != '0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      buf_q   <= '0;
      cnt_q   <= '0;
      ended_q <= 1'b0;
      sent_q  <= '0;
    end else begin
      // An atom arriving with a transfer starts the next frame.
      if (xfer) begin
        buf_q <= push ? BUF_W'(bus.atom) : '0;
        cnt_q <= push ? CNT4_W'(1) : '0;
      end else if (push) begin
        buf_q <= {buf_q[BUF_W-ATOM_W-1:0], bus.atom};
        cnt_q <= cnt_q + CNT4_W'(1);
      end

      if (take && (sent_q != '1)) begin
        sent_q <= sent_q + CNT_W'(1);
      end

      case (state)
        RUN: begin
          if (bus.test_ending) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if ((cnt_q == '0) && !frame_valid) begin
            state   <= DONE;
            ended_q <= 1'b1;
          end
        end
        default: begin
          state <= DONE;
        end
      endcase
    end
  end

  sopc_video_cpu_dct_frame_reg #(
    .DATA_W  (BUF_W),
    .COUNT_W (CNT4_W)
  ) u_frame_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (xfer),
    .load_data  (buf_q),
    .load_count (cnt_q),
    .ready      (bus.frame_ready),
    .valid      (frame_valid),
    .data       (frame_data),
    .count      (frame_count)
  );

  assign bus.dct_buffer     = buf_q;
  assign bus.dct_count      = cnt_q;
  assign bus.frame_valid    = frame_valid;
  assign bus.frame_data     = frame_data;
  assign bus.frame_count    = frame_count;
  assign bus.test_has_ended = ended_q;
  assign bus.frames_sent    = sent_q;

endmodule

// File: tb/tb_sopc_video_cpu_dct_drain_ctrl.sv
// tb/tb_sopc_video_cpu_dct_drain_ctrl.sv - directed self-checking bench for the trace drain controller
module tb_sopc_video_cpu_dct_drain_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic reset2;

  always #5 clk = ~clk;

  sopc_video_cpu_dct_drain_ctrl_if bus ();
  sopc_video_cpu_dct_drain_ctrl_if #(.CNT_W(2)) bus2 ();

  sopc_video_cpu_dct_drain_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Narrow counter instance so saturation is reachable in a few frames.
  sopc_video_cpu_dct_drain_ctrl #(.CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    reset2          = 1'b1;
    bus.atom_valid  = 1'b0;
    bus.atom        = 2'd0;
    bus.test_ending = 1'b0;
    bus.frame_ready = 1'b0;
    bus2.atom_valid  = 1'b1;
    bus2.atom        = 2'd0;
    bus2.test_ending = 1'b0;
    bus2.frame_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("rst_buffer", 32'(bus.dct_buffer), 32'h0);
    check("rst_count", 32'(bus.dct_count), 32'd0);
    check("rst_fvalid", 32'(bus.frame_valid), 32'd0);
    check("rst_fdata", 32'(bus.frame_data), 32'h0);
    check("rst_fcount", 32'(bus.frame_count), 32'd0);
    check("rst_ended", 32'(bus.test_has_ended), 32'd0);
    check("rst_sent", 32'(bus.frames_sent), 32'd0);
    check("rst_aready", 32'(bus.atom_ready), 32'd1);

    // Full frame with atoms 0,1,2,3,... and an always-ready sink.
    bus.frame_ready = 1'b1;
    bus.atom_valid  = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.atom = 2'(i % 4);
      tick();
    end
    bus.atom_valid = 1'b0;
    check("t1_count15", 32'(bus.dct_count), 32'd15);
    check("t1_buffer", 32'(bus.dct_buffer), 32'h06C6C6C6);
    check("t1_fvalid_pre", 32'(bus.frame_valid), 32'd0);
    tick();
    check("t1_fvalid", 32'(bus.frame_valid), 32'd1);
    check("t1_fdata", 32'(bus.frame_data), 32'h06C6C6C6);
    check("t1_fcount", 32'(bus.frame_count), 32'd15);
    check("t1_count0", 32'(bus.dct_count), 32'd0);
    tick();
    check("t1_sent", 32'(bus.frames_sent), 32'd1);
    check("t1_fvalid_post", 32'(bus.frame_valid), 32'd0);

    // Backpressure: 30 accepted atoms, the 31st held until the sink frees up.
    bus.frame_ready = 1'b0;
    bus.atom_valid  = 1'b1;
    bus.atom        = 2'd1;
    repeat (15) tick();
    bus.atom = 2'd2;
    repeat (15) tick();
    check("t2_count", 32'(bus.dct_count), 32'd15);
    check("t2_fvalid", 32'(bus.frame_valid), 32'd1);
    check("t2_fdata1", 32'(bus.frame_data), 32'h15555555);
    check("t2_fcount1", 32'(bus.frame_count), 32'd15);
    check("t2_buffer", 32'(bus.dct_buffer), 32'h2AAAAAAA);
    bus.atom = 2'd3;
    #1;
    check("t2_aready_full", 32'(bus.atom_ready), 32'd0);
    tick();
    check("t2_count_held", 32'(bus.dct_count), 32'd15);
    check("t2_fdata_stable", 32'(bus.frame_data), 32'h15555555);
    bus.frame_ready = 1'b1;
    #1;
    check("t2_aready_free", 32'(bus.atom_ready), 32'd1);
    tick();
    bus.atom_valid = 1'b0;
    check("t2_fdata2", 32'(bus.frame_data), 32'h2AAAAAAA);
    check("t2_fcount2", 32'(bus.frame_count), 32'd15);
    check("t2_count1", 32'(bus.dct_count), 32'd1);
    check("t2_buffer1", 32'(bus.dct_buffer), 32'h3);
    check("t2_sent2", 32'(bus.frames_sent), 32'd2);
    tick();
    check("t2_sent3", 32'(bus.frames_sent), 32'd3);
    check("t2_fvalid_post", 32'(bus.frame_valid), 32'd0);

    // Partial flush of five 2'b11 atoms.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.frame_ready = 1'b1;
    bus.atom_valid  = 1'b1;
    bus.atom        = 2'd3;
    repeat (5) tick();
    bus.atom_valid  = 1'b0;
    bus.test_ending = 1'b1;
    tick();
    bus.test_ending = 1'b0;
    check("t3_count5", 32'(bus.dct_count), 32'd5);
    check("t3_aready_flush", 32'(bus.atom_ready), 32'd0);
    tick();
    check("t3_fvalid", 32'(bus.frame_valid), 32'd1);
    check("t3_fdata", 32'(bus.frame_data), 32'h3FF);
    check("t3_fcount", 32'(bus.frame_count), 32'd5);
    check("t3_count0", 32'(bus.dct_count), 32'd0);
    tick();
    check("t3_sent", 32'(bus.frames_sent), 32'd1);
    check("t3_ended_pre", 32'(bus.test_has_ended), 32'd0);
    tick();
    check("t3_ended", 32'(bus.test_has_ended), 32'd1);
    bus.atom_valid = 1'b1;
    #1;
    check("t3_aready_done", 32'(bus.atom_ready), 32'd0);
    bus.atom_valid = 1'b0;

    // Flush with nothing buffered.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.test_ending = 1'b1;
    tick();
    check("t4_ended_early", 32'(bus.test_has_ended), 32'd0);
    tick();
    bus.test_ending = 1'b0;
    check("t4_ended", 32'(bus.test_has_ended), 32'd1);
    check("t4_sent", 32'(bus.frames_sent), 32'd0);

    // Reset with a pending frame and 7 buffered atoms.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.frame_ready = 1'b0;
    bus.atom_valid  = 1'b1;
    bus.atom        = 2'd1;
    repeat (22) tick();
    bus.atom_valid = 1'b0;
    check("t5_fvalid_pre", 32'(bus.frame_valid), 32'd1);
    check("t5_count_pre", 32'(bus.dct_count), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_buffer", 32'(bus.dct_buffer), 32'h0);
    check("t5_count", 32'(bus.dct_count), 32'd0);
    check("t5_fvalid", 32'(bus.frame_valid), 32'd0);
    check("t5_fdata", 32'(bus.frame_data), 32'h0);
    check("t5_fcount", 32'(bus.frame_count), 32'd0);
    check("t5_ended", 32'(bus.test_has_ended), 32'd0);
    check("t5_sent", 32'(bus.frames_sent), 32'd0);

    // Four frames through a 2-bit counter must stop at all-ones.
    reset2 = 1'b0;
    repeat (70) tick();
    check("t6_sat", 32'(bus2.frames_sent), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sopc_video_cpu_dct_drain_ctrl.md
Name: sopc_video_cpu_dct_drain_ctrl

Overview:
- Sequencing controller for the CPU debug-trace capture buffer: the 30-bit dct_buffer holding up to 15 two-bit trace atoms, plus the 4-bit dct_count.
- Accepts atoms from the trace source and packs them into the buffer.
- Hands full, or flushed partial, buffers to a single-entry frame register drained by the JTAG/host side over a valid/ready handshake.
- Sequences end-of-test flush and signals test_has_ended. Sits between the OCI trace source and the debug transport.

Parameters:
- ATOM_W, 2, bits per trace atom.
- DEPTH, 15, atoms per frame; DEPTH*ATOM_W = 30 = dct_buffer width.
- CNT_W, 16, width of the saturating frames-sent counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- atom_valid  in  1  trace source presents an atom.
- atom  in  2  trace atom.
- atom_ready  out  1  atom accepted on this edge when atom_valid && atom_ready.
- test_ending  in  1  level; request final flush.
- dct_buffer  out  30  live packing buffer; newest atom in [1:0].
- dct_count  out  4  atoms currently in dct_buffer, 0..15.
- frame_valid  out  1  frame register holds a frame.
- frame_data  out  30  frame contents.
- frame_count  out  4  valid atoms in frame_data, 1..15.
- frame_ready  in  1  sink accepts the frame.
- test_has_ended  out  1  sticky; final frame delivered.
- frames_sent  out  CNT_W  saturating count of accepted frames.

Behaviour:
- Reset (sync, high) values:
  - dct_buffer=0, dct_count=0.
  - frame_valid=0, frame_data=0, frame_count=0.
  - test_has_ended=0, frames_sent=0.
  - state=RUN.
- Reset asserted mid-operation discards the buffer and any pending frame with no handshake.
- States:
  - RUN: normal capture.
  - FLUSH: test_ending seen; draining.
  - DONE: terminal until reset.
- Definitions:
  - slot_free = !frame_valid || frame_ready.
  - push = atom_valid && atom_ready.
  - xfer (RUN) = dct_count==DEPTH && slot_free.
- atom_ready:
  - RUN: (dct_count<DEPTH) || slot_free.
  - FLUSH and DONE: 0.
- Push without xfer: dct_buffer <= {dct_buffer[27:0], atom}; dct_count+1. The atom is visible on outputs the next cycle.
- xfer:
  - frame_data <= dct_buffer, frame_count <= dct_count, frame_valid <= 1.
  - dct_buffer <= push ? {28'b0, atom} : 0.
  - dct_count <= push ? 1 : 0.
- Latency: the push making count 15 at edge N gives dct_count==15 after N; xfer occurs at edge N+1 if slot_free, so frame_valid is high after N+1.
- Frame handshake: frame_valid && frame_ready at an edge retires the frame.
  - frames_sent+1, saturating at all-ones.
  - frame_valid <= 0 unless a new xfer loads it the same edge. Back-to-back frames are allowed.
- frame_data and frame_count stay stable while frame_valid && !frame_ready.
- Full buffer with slot occupied: atom_ready=0 (backpressure). No atom is ever dropped or overwritten.
- RUN->FLUSH: test_ending sampled high at an edge.
  - If a push occurs on that same edge, the atom is accepted first.
- FLUSH:
  - If dct_count>0 and slot_free: partial xfer (frame_count=dct_count, unused high bits zero), buffer cleared.
  - If dct_count==0 and frame_valid==0: go to DONE; test_has_ended <= 1.
- DONE: test_has_ended stays 1; atom_ready=0; test_ending ignored.
- test_ending deasserting during FLUSH does not abort the flush.

Decomposition:
- Shared package sopc_video_cpu_dct_pkg holds:
  - ATOM_W, DEPTH, BUF_W=30, CNT4_W=4.
  - State encoding RUN=2'd0, FLUSH=2'd1, DONE=2'd2.
- Natural sub-module: sopc_video_cpu_dct_frame_reg, the single-entry valid/ready holding register for frame_data and frame_count. It is reused by the host-side trace path.

Test Plan:
- Push 15 atoms 0,1,2,3,0,… with frame_ready=1:
  - dct_count reaches 15.
  - Next edge: frame_valid=1, frame_data=30'h06C6C6C6 (in push order), frame_count=15, dct_count=0.
  - frames_sent=1 after acceptance.
- frame_ready=0, push 31 atoms:
  - Frame 1 is held stable.
  - Buffer fills to 15; atom_ready=0 on the 31st attempt.
  - Raise frame_ready: frame 1 retires and frame 2 loads the same edge; the 31st atom lands with dct_count=1.
- Push 5 atoms of 2'b11, then pulse test_ending:
  - Partial frame frame_data=30'h3FF, frame_count=5.
  - After acceptance: test_has_ended=1, atom_ready=0.
- test_ending with empty buffer and no frame: test_has_ended=1 two edges later; frames_sent unchanged.
- Reset asserted while frame_valid=1 and dct_count=7: all outputs return to reset values next edge; no handshake required.
- Force frames_sent to 16'hFFFF, accept one more frame: frames_sent remains 16'hFFFF.
